if_fetch: RTL
=============

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port stall  input  6  pipeline stall vector; bit0 = hold PC, bit1 = hold IF; bits 5:2 unused.
REQ-005 SHALL have port branch_flag  input  1  one-cycle redirect request.
REQ-006 SHALL have port branch_target  input  32  redirect byte address, used unmodified.
REQ-007 SHALL have port mem_req  output  1  byte-read request to the memory controller.
REQ-008 SHALL have port mem_addr  output  32  byte address of the pending read.
REQ-009 SHALL have port mem_ack  input  1  one-cycle pulse: mem_data holds the byte at mem_addr.
REQ-010 SHALL have port mem_data  input  8  returned byte.
REQ-011 SHALL have port stall_req  output  1  requests a pipeline stall while no instruction is ready.
REQ-012 SHALL have port pc_o  output  32  address of the instruction presented to the IF/ID register.
REQ-013 SHALL have port inst_o  output  32  assembled instruction word.

Function
REQ-014 SHALL implement states FETCH, DONE and FLUSH, plus a 2-bit byte counter cnt and a 32-bit pc register.
REQ-015 In FETCH, SHALL drive mem_req=1 and mem_addr=pc+cnt (32-bit wrap), each held stable until mem_ack.
REQ-016 On mem_ack in FETCH, SHALL store mem_data into byte lane cnt (little-endian, lane0 = inst[7:0]) and increment cnt.
REQ-017 On mem_ack with cnt=3 in FETCH, SHALL enter DONE next cycle with pc_o=pc and inst_o=assembled word; latency from the last ack to DONE is 1 cycle.
REQ-018 SHALL drive stall_req=1 in FETCH and FLUSH and stall_req=0 in DONE, decoded from state.
REQ-019 In DONE with stall[0]=0 and branch_flag=0, SHALL set pc<=pc+4 (wrap to 0 above 32'hFFFF_FFFC), cnt<=0, and enter FETCH.
REQ-020 In DONE with stall[0]=1 and branch_flag=0, SHALL hold state, pc, pc_o and inst_o.
REQ-021 branch_flag SHALL take priority over stall in every state and always load pc<=branch_target and cnt<=0.
REQ-022 On branch_flag in DONE, or in FETCH coincident with mem_ack, SHALL discard any partial word and enter FETCH at the new pc; the coincident byte is dropped.
REQ-023 On branch_flag in FETCH without mem_ack, SHALL enter FLUSH with mem_req and mem_addr held at the outstanding address.
REQ-024 In FLUSH, SHALL hold the request until mem_ack, discard that byte, and enter FETCH at pc next cycle.
REQ-025 On branch_flag in FLUSH, SHALL overwrite pc with the newest target and remain in FLUSH.
REQ-026 SHALL drive pc_o=0 and inst_o=0 in all states other than DONE.
REQ-027 SHALL ignore mem_ack in DONE.
REQ-028 SHALL drive mem_req=0 in DONE.
REQ-029 SHALL ignore stall bits 5:1 internally, since the IF/ID register interprets them.

Reset
REQ-030 While reset=1 at a clock edge, SHALL set state=FETCH, pc=RESET_PC, cnt=0, pc_o=0, inst_o=0 and byte lanes=0.
REQ-031 After reset, SHALL present mem_req=1, mem_addr=RESET_PC and stall_req=1.
REQ-032 Reset asserted mid-fetch or mid-flush SHALL abandon the outstanding read without waiting for mem_ack.

Verification
REQ-033 Basic fetch: reset; acks with bytes 13,05,50,00 at addresses 0..3 -> next cycle DONE with pc_o=0, inst_o=32'h0050_0513, stall_req=0.
REQ-034 Advance/hold: in DONE, stall=6'b000011 for 3 cycles, then 0 -> outputs held 3 cycles, then mem_addr=4 and stall_req=1.
REQ-035 Redirect at boundary: branch_flag with target 32'h100 coincident with the 3rd ack of the fetch at 0x8 -> next mem_addr=32'h100, cnt=0, no DONE for 0x8.
REQ-036 Flush: branch_flag (target 32'h40) then a second branch_flag (target 32'h80) while waiting on address 0x5 -> mem_addr stays 0x5 until ack, then 0x80, 0x81, 0x82, 0x83, and pc_o=32'h80.
REQ-037 Wrap: RESET_PC=32'hFFFF_FFFC -> addresses FFFF_FFFC..FFFF_FFFF, then advance gives mem_addr=0.
REQ-038 Reset mid-fetch after 2 acks -> next cycle mem_addr=RESET_PC, cnt=0, inst_o=0.

Source files
------------

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch stage for a byte-wide memory port.
//
// Assembles one 32-bit little-endian instruction from four byte reads at
// pc..pc+3 and presents it to the IF/ID register for as long as the pipeline
// holds it. Branch redirects take priority over stalls. A redirect that
// arrives while a read is outstanding parks the FSM in FLUSH, which waits
// for that read's ack and discards the byte.
//
// Ports
//   clock          rising-edge clock
//   reset          synchronous, active-high reset
//   stall[5:0]     pipeline stall vector; only bit0 (hold PC) is used here
//   branch_flag    one-cycle redirect request
//   branch_target  redirect byte address
//   mem_req        byte-read request (FETCH/FLUSH)
//   mem_addr       byte address of the pending read
//   mem_ack        one-cycle pulse, mem_data valid
//   mem_data       returned byte
//   stall_req      high while no instruction is ready
//   pc_o           address of the presented instruction (0 unless DONE)
//   inst_o         presented instruction word (0 unless DONE)
// ---------------------------------------------------------------------------
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic        stall_req,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    DONE  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [1:0]  r_cnt;
  logic [1:0]  w_cnt_next;
  logic [31:0] r_inst;
  logic [31:0] w_inst_next;
  logic [31:0] r_flush_addr;
  logic [31:0] w_flush_addr_next;
  logic [31:0] w_fetch_addr;
  logic        w_stall_unused;

  // Bits 5:1 belong to the IF/ID register.
  assign w_stall_unused = ^stall[5:1];

  assign w_fetch_addr = r_pc + {30'd0, r_cnt};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_cnt        <= '0;
      r_inst       <= '0;
      r_flush_addr <= '0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_cnt        <= w_cnt_next;
      r_inst       <= w_inst_next;
      r_flush_addr <= w_flush_addr_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_cnt_next        = r_cnt;
    w_inst_next       = r_inst;
    w_flush_addr_next = r_flush_addr;
    case (r_state)
      FETCH: begin
        if (branch_flag) begin
          w_pc_next  = branch_target;
          w_cnt_next = '0;
          // Without an ack the read is still in flight: remember where it
          // went so the request can be held stable until it completes.
          if (!mem_ack) begin
            w_flush_addr_next = w_fetch_addr;
            w_state_next      = FLUSH;
          end
        end else if (mem_ack) begin
          w_inst_next[{r_cnt, 3'b000} +: 8] = mem_data;
          w_cnt_next = r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            w_state_next = DONE;
          end
        end
      end
      DONE: begin
        if (branch_flag) begin
          w_pc_next    = branch_target;
          w_cnt_next   = '0;
          w_state_next = FETCH;
        end else if (!stall[0]) begin
          w_pc_next    = r_pc + 32'd4;
          w_cnt_next   = '0;
          w_state_next = FETCH;
        end
      end
      FLUSH: begin
        if (branch_flag) begin
          w_pc_next  = branch_target;
          w_cnt_next = '0;
        end
        // The ack retires the abandoned read; its byte is dropped.
        if (mem_ack) begin
          w_state_next = FETCH;
        end
      end
      default: begin
        w_state_next = FETCH;
      end
    endcase
  end

  always_comb begin
    mem_req   = (r_state != DONE);
    stall_req = (r_state != DONE);
    mem_addr  = (r_state == FLUSH) ? r_flush_addr : w_fetch_addr;
    pc_o      = (r_state == DONE) ? r_pc   : '0;
    inst_o    = (r_state == DONE) ? r_inst : '0;
  end

endmodule
